maxpool_2x2: RTL
================

# maxpool_2x2

Streaming 2x2 stride-2 max-pool stage that sits directly downstream of `conv`. It consumes the six-channel signed feature vectors that `conv` emits in raster order (24x24 per frame for a 28x28 input with a 5x5 kernel) and produces a 12x12x6 pooled map in raster order. It has no backpressure: it accepts every valid beat `conv` offers, and its own output is single-beat valid-only.

## Interface
Parameters:
- `IN_ROWS`, default 24: rows per input frame; must be even.
- `IN_COLS`, default 24: columns per input frame; must be even.
- `CHANNELS`, default 6: parallel feature channels.
- `DATA_W`, default 8: signed feature width.

Ports:
- `i_clk`, in, 1: sole clock, rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_feature_valid`, in, 1: input beat valid; driven by `conv`'s `o_feature_valid`.
- `i_features[0:CHANNELS-1]`, in, signed `DATA_W` each: one input pixel, all channels.
- `o_feature_valid`, out, 1: pooled beat valid; single-cycle pulse per pooled pixel.
- `o_features[0:CHANNELS-1]`, out, signed `DATA_W` each: pooled pixel.
- `o_frame_done`, out, 1: one-cycle pulse, coincident with the last pooled beat of a frame.

## Operation
- Counters `row_ctr` (0..IN_ROWS-1) and `col_ctr` (0..IN_COLS-1) advance only on `i_feature_valid`.
- `col_ctr` wraps at IN_COLS-1 and increments `row_ctr` at that point. `row_ctr` wraps to 0 after IN_ROWS-1, so the next frame follows immediately with no idle cycle required.
- All comparisons are signed, per channel, independent across channels. There is no saturation and no width growth; the output is exactly one of the input values.
- Even column (any row): latch the input into the `hold` register.
- Even row, odd column: write max(hold, input) into line buffer entry `col_ctr>>1`. The buffer has IN_COLS/2 entries of CHANNELS x DATA_W.
- Odd row, odd column: compute max(hold, input, linebuf[`col_ctr>>1`]) and register it to `o_features`. Pulse `o_feature_valid`.
- On the beat with `row_ctr`=IN_ROWS-1 and `col_ctr`=IN_COLS-1, `o_frame_done` pulses in the same cycle as the corresponding `o_feature_valid`.
- Gaps in `i_feature_valid` of any length are legal. No state changes while it is low.
- `o_features` holds its last value between pulses.

## Timing
- Latency is 1 cycle: the beat accepted at edge N (odd row, odd column) gives `o_feature_valid`=1 after edge N, observed in cycle N+1.
- Full-rate input yields one output every 2 cycles during odd rows and none during even rows.
- Reset values: `o_feature_valid`=0, `o_frame_done`=0, `o_features`=all 0, counters=0, `hold`=0. Line buffer contents are don't-care, because an even row always rewrites them before they are read.
- Reset mid-frame: the next valid beat is treated as row 0, column 0. No output pulse may be issued from pre-reset data.
- Reset asserted in the same cycle as `i_feature_valid`: reset wins and the beat is dropped.
- The line buffer is read and written at the same entry only on different rows, so there is no read/write hazard.

## Structure
- Shared package `conv_pkg` holds `CHANNELS`, `DATA_W`, `FEATURE_ROWS`/`FEATURE_COLS` (24) and the typedef `feature_vec_t` (`logic signed [DATA_W-1:0] [0:CHANNELS-1]`). `conv` and this block both import it.
- One sub-module, `pool_line_buffer`: a single-port, IN_COLS/2-deep array of `feature_vec_t` with write enable and a combinational read (distributed RAM).
- A per-channel `max2` function lives in the same package.

## Test plan
- Ramp: channel c pixel(r,col) = (r+col) for c even and -(r+col) for c odd, full rate. Expect 144 outputs; pooled (i,j) is 2i+2j+2 on even channels and -(2i+2j) on odd channels; `o_frame_done` only on (11,11).
- Signed extremes: one window of {-128, 127, -1, 0} on all channels. Expect 127; an all -128 window gives -128.
- Bubbles: same ramp with `i_feature_valid` randomly low about 50% of cycles. Expect outputs identical to the ramp case, each exactly 1 cycle after its 4th window beat.
- Mid-frame reset: assert `i_rst` for 1 cycle at row 7 column 13, then restart the ramp. Expect no pulse between reset and the restarted row 1 column 1, then the full 144 correct outputs.
- Back-to-back frames: two ramp frames with no gap, the second offset by +1. Expect 288 outputs, the second frame's values increased by 1, and two `o_frame_done` pulses exactly 576 input beats apart.
- End-to-end: `conv` driven with a 0..783 counting stream, this block on its output. Expect the pooled result to match a golden model of conv followed by max-pool.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv -> maxpool feature path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a; the feature path is valid-only with no ready signal.
package conv_pkg;

  localparam int CHANNELS     = 6;
  localparam int DATA_W       = 8;
  localparam int FEATURE_ROWS = 24;
  localparam int FEATURE_COLS = 24;

  typedef logic signed [DATA_W-1:0] feature_t;
  typedef feature_t [0:CHANNELS-1]  feature_vec_t;

  // Signed max of one channel. Element selects of packed arrays lose their
  // signedness, so both operands are re-signed explicitly before comparing.
  function automatic feature_t max2(input feature_t a, input feature_t b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row store of horizontal pair maxima for the 2x2 pooling window.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module pool_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = FEATURE_COLS / 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  feature_vec_t  wr_dat,
  output feature_vec_t  rd_dat
);

  // No reset: every entry is rewritten on an even row before an odd row reads it.
  feature_vec_t mem [DEPTH];

  // Single-port write at the shared address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[addr];

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order multi-channel frame.
// Latency: 1 cycle from the fourth beat of a window to o_feature_valid.
// Backpressure: none; every valid input beat is consumed, output is valid-only.
module maxpool_2x2
  import conv_pkg::*;
#(
  // CHANNELS and DATA_W must agree with conv_pkg: the line buffer and the
  // hold register are stored as conv_pkg::feature_vec_t.
  parameter int IN_ROWS  = FEATURE_ROWS,
  parameter int IN_COLS  = FEATURE_COLS,
  parameter int CHANNELS = conv_pkg::CHANNELS,
  parameter int DATA_W   = conv_pkg::DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_feature_valid,
  input  logic signed [DATA_W-1:0] i_features [0:CHANNELS-1],
  output logic                     o_feature_valid,
  output logic signed [DATA_W-1:0] o_features [0:CHANNELS-1],
  output logic                     o_frame_done
);

  localparam int ROW_W    = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int COL_W    = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int LB_DEPTH = IN_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [ROW_W-1:0] row_ctr;
  logic [COL_W-1:0] col_ctr;
  logic             last_row;
  logic             last_col;
  logic             lb_wr_en;
  logic [LB_AW-1:0] lb_addr;
  feature_vec_t     hold;
  feature_vec_t     lb_wr_dat;
  feature_vec_t     lb_rd_dat;
  feature_vec_t     pooled;

  assign last_row = (row_ctr == ROW_W'(IN_ROWS - 1));
  assign last_col = (col_ctr == COL_W'(IN_COLS - 1));

  // Column pairs share one entry; the even row writes it, the odd row reads it.
  assign lb_addr  = LB_AW'(col_ctr >> 1);
  // Reset outranks a coincident beat, so that beat must not touch the buffer.
  assign lb_wr_en = i_feature_valid && !i_rst && col_ctr[0] && !row_ctr[0];

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk    (i_clk),
    .wr_en  (lb_wr_en),
    .addr   (lb_addr),
    .wr_dat (lb_wr_dat),
    .rd_dat (lb_rd_dat)
  );

  // Horizontal pair max (buffered on even rows) and full window max (odd rows).
  always_comb begin
    lb_wr_dat = '0;
    pooled    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lb_wr_dat[c] = max2(hold[c], i_features[c]);
      pooled[c]    = max2(lb_wr_dat[c], lb_rd_dat[c]);
    end
  end

  // Raster position tracking, hold latch and registered pooled output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_ctr         <= '0;
      col_ctr         <= '0;
      hold            <= '0;
      o_feature_valid <= 1'b0;
      o_frame_done    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        o_features[c] <= '0;
      end
    end else begin
      o_feature_valid <= 1'b0;
      o_frame_done    <= 1'b0;
      if (i_feature_valid) begin
        if (last_col) begin
          col_ctr <= '0;
          row_ctr <= last_row ? '0 : row_ctr + 1'b1;
        end else begin
          col_ctr <= col_ctr + 1'b1;
        end

        if (!col_ctr[0]) begin
          for (int c = 0; c < CHANNELS; c++) begin
            hold[c] <= i_features[c];
          end
        end else if (row_ctr[0]) begin
          for (int c = 0; c < CHANNELS; c++) begin
            o_features[c] <= pooled[c];
          end
          o_feature_valid <= 1'b1;
          o_frame_done    <= last_row && last_col;
        end
      end
    end
  end

endmodule
